config_frame_sequencer: RTL and testbench

- Upstream feeder of the per-column frame strobe decoder.
- Consumes 32-bit configuration words from the bitstream word source (UART/bit-bang front end). Parses a sync word and then per-frame headers. Distributes frame data words row by row into the frame data registers.
- Finishes each frame with a single-cycle frame strobe carrying column select and 1-based frame index. Every column decoder compares these against its own column.

---
 rtl/cfg_pkg.sv | 30 +++
 rtl/cfg_header_decode.sv | 38 +++
 rtl/config_frame_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_config_frame_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
`default_nettype none
//============================================================================
// Module  : cfg_pkg
// Purpose : Shared types and constants for the configuration frame
//           sequencer and the bitstream checker: sequencer state
//           encoding, default sync word, END column code and the bit
//           positions of the header fields.
// Revision: 1.0 - initial release
//============================================================================
package cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_STROBE = 2'd3
    } cfgState_t;

    localparam logic [31:0] c_SYNC_WORD        = 32'hFAB0_FAB1;
    localparam int          c_FRAME_SEL_WIDTH  = 5;

    // END is signalled by an all-ones column; sliced to the column width.
    localparam logic [31:0] c_END_COLUMN       = 32'hFFFF_FFFF;

    // Column occupies the top bits of a header word, index the bottom bits.
    localparam int          c_HDR_COL_MSB      = 31;
    localparam int          c_HDR_IDX_LSB      = 0;

endpackage : cfg_pkg
`default_nettype wire

// File: rtl/cfg_header_decode.sv
`default_nettype none
//============================================================================
// Module  : cfg_header_decode
// Purpose : Combinational split of a 32-bit header word into its column
//           and frame-index fields plus END / sync / index-range flags.
// Ports   : i_headerWord  - candidate header word
//           o_column      - column select field
//           o_index       - 1-based frame index field
//           o_isEnd       - column field is the END code
//           o_isSync      - whole word equals the sync word
//           o_indexValid  - index within 1..MaxFramesPerCol
// Revision: 1.0 - initial release
//============================================================================
module cfg_header_decode
    import cfg_pkg::*;
#(
    parameter int          FrameSelectWidth = c_FRAME_SEL_WIDTH,
    parameter int          IndexWidth       = 5,
    parameter int          MaxFramesPerCol  = 20,
    parameter logic [31:0] SyncWord         = c_SYNC_WORD
) (
    input  logic [31:0]                 i_headerWord,
    output logic [FrameSelectWidth-1:0] o_column,
    output logic [IndexWidth-1:0]       o_index,
    output logic                        o_isEnd,
    output logic                        o_isSync,
    output logic                        o_indexValid
);

    assign o_column     = i_headerWord[c_HDR_COL_MSB -: FrameSelectWidth];
    assign o_index      = i_headerWord[c_HDR_IDX_LSB +: IndexWidth];
    assign o_isEnd      = (o_column == c_END_COLUMN[FrameSelectWidth-1:0]);
    assign o_isSync     = (i_headerWord == SyncWord);
    assign o_indexValid = (o_index != '0) &&
                          (o_index <= IndexWidth'(MaxFramesPerCol));

endmodule : cfg_header_decode
`default_nettype wire

// File: rtl/config_frame_sequencer.sv
`default_nettype none
//============================================================================
// Module  : config_frame_sequencer
// Purpose : Parses the configuration word stream (sync word, frame
//           headers, row data), loads frame data registers row by row and
//           commits each frame with a single-cycle frame strobe.
// Ports   : CLK, reset          - clock, synchronous active-high reset
//           WriteData/Strobe    - incoming word and its valid flag
//           WriteReady          - word accepted when strobe && ready
//           RowSelect/FrameData/FrameDataStrobe - row load interface
//           FrameSelect/FrameIndex/FrameStrobe  - frame commit to decoders
//           ConfigActive        - between sync word and END
//           ConfigError         - sticky bad-index flag, cleared by sync
// Revision: 1.0 - initial release
//============================================================================
module config_frame_sequencer
    import cfg_pkg::*;
#(
    parameter int          NumberOfRows     = 16,
    parameter int          RowSelectWidth   = 5,
    parameter int          MaxFramesPerCol  = 20,
    parameter int          FrameSelectWidth = c_FRAME_SEL_WIDTH,
    parameter logic [31:0] SyncWord         = c_SYNC_WORD
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic [31:0]                          WriteData,
    input  logic                                 WriteStrobe,
    output logic                                 WriteReady,
    output logic [RowSelectWidth-1:0]            RowSelect,
    output logic [31:0]                          FrameData,
    output logic                                 FrameDataStrobe,
    output logic [FrameSelectWidth-1:0]          FrameSelect,
    output logic [$clog2(MaxFramesPerCol+1)-1:0] FrameIndex,
    output logic                                 FrameStrobe,
    output logic                                 ConfigActive,
    output logic                                 ConfigError
);

    localparam int c_INDEX_WIDTH = $clog2(MaxFramesPerCol + 1);
    localparam logic [RowSelectWidth-1:0] c_LAST_ROW = RowSelectWidth'(NumberOfRows - 1);

    cfgState_t                     r_state,        w_nextState;
    logic [RowSelectWidth-1:0]     r_rowCount,     w_nextRowCount;
    logic [FrameSelectWidth-1:0]   r_latchCol,     w_nextLatchCol;
    logic [c_INDEX_WIDTH-1:0]      r_latchIdx,     w_nextLatchIdx;
    logic                          r_frameValid,   w_nextFrameValid;
    logic                          r_writeReady;
    logic [RowSelectWidth-1:0]     r_rowSelect,    w_nextRowSelect;
    logic [31:0]                   r_frameData,    w_nextFrameData;
    logic                          r_dataStrobe,   w_nextDataStrobe;
    logic [FrameSelectWidth-1:0]   r_frameSelect,  w_nextFrameSelect;
    logic [c_INDEX_WIDTH-1:0]      r_frameIndex,   w_nextFrameIndex;
    logic                          r_frameStrobe,  w_nextFrameStrobe;
    logic                          r_configActive, w_nextConfigActive;
    logic                          r_configError,  w_nextConfigError;

    logic                          w_accept;
    logic [FrameSelectWidth-1:0]   w_hdrColumn;
    logic [c_INDEX_WIDTH-1:0]      w_hdrIndex;
    logic                          w_hdrIsEnd;
    logic                          w_hdrIsSync;
    logic                          w_hdrIndexValid;

    assign w_accept = WriteStrobe && r_writeReady;

    cfg_header_decode #(
        .FrameSelectWidth (FrameSelectWidth),
        .IndexWidth       (c_INDEX_WIDTH),
        .MaxFramesPerCol  (MaxFramesPerCol),
        .SyncWord         (SyncWord)
    ) u_headerDecode (
        .i_headerWord (WriteData),
        .o_column     (w_hdrColumn),
        .o_index      (w_hdrIndex),
        .o_isEnd      (w_hdrIsEnd),
        .o_isSync     (w_hdrIsSync),
        .o_indexValid (w_hdrIndexValid)
    );

    always_comb begin
        w_nextState        = r_state;
        w_nextRowCount     = r_rowCount;
        w_nextLatchCol     = r_latchCol;
        w_nextLatchIdx     = r_latchIdx;
        w_nextFrameValid   = r_frameValid;
        w_nextRowSelect    = r_rowSelect;
        w_nextFrameData    = r_frameData;
        w_nextDataStrobe   = 1'b0;
        w_nextFrameSelect  = r_frameSelect;
        w_nextFrameIndex   = r_frameIndex;
        w_nextFrameStrobe  = 1'b0;
        w_nextConfigActive = r_configActive;
        w_nextConfigError  = r_configError;

        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_hdrIsSync) begin
                    w_nextState        = ST_HEADER;
                    w_nextConfigActive = 1'b1;
                    w_nextConfigError  = 1'b0;
                end
            end
            ST_HEADER: begin
                if (w_accept) begin
                    // The sync word's top bits are all ones, so the sync
                    // test must win over the END test.
                    if (w_hdrIsSync) begin
                        w_nextConfigError = 1'b0;
                    end else if (w_hdrIsEnd) begin
                        w_nextState        = ST_IDLE;
                        w_nextConfigActive = 1'b0;
                        w_nextFrameSelect  = '0;
                        w_nextFrameIndex   = '0;
                    end else begin
                        w_nextState      = ST_DATA;
                        w_nextLatchCol   = w_hdrColumn;
                        w_nextLatchIdx   = w_hdrIndex;
                        w_nextRowCount   = '0;
                        w_nextFrameValid = w_hdrIndexValid;
                        if (!w_hdrIndexValid) begin
                            w_nextConfigError = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_nextRowSelect  = r_rowCount;
                    w_nextFrameData  = WriteData;
                    w_nextDataStrobe = 1'b1;
                    w_nextRowCount   = r_rowCount + 1'b1;
                    if (r_rowCount == c_LAST_ROW) begin
                        w_nextState = ST_STROBE;
                    end
                end
            end
            ST_STROBE: begin
                // Commit appears the cycle after the stall, so it never
                // overlaps the last row's data strobe.
                w_nextFrameSelect = r_latchCol;
                w_nextFrameIndex  = r_latchIdx;
                w_nextFrameStrobe = r_frameValid;
                w_nextState       = ST_HEADER;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_rowCount     <= '0;
            r_latchCol     <= '0;
            r_latchIdx     <= '0;
            r_frameValid   <= 1'b0;
            r_writeReady   <= 1'b1;
            r_rowSelect    <= '0;
            r_frameData    <= '0;
            r_dataStrobe   <= 1'b0;
            r_frameSelect  <= '0;
            r_frameIndex   <= '0;
            r_frameStrobe  <= 1'b0;
            r_configActive <= 1'b0;
            r_configError  <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_rowCount     <= w_nextRowCount;
            r_latchCol     <= w_nextLatchCol;
            r_latchIdx     <= w_nextLatchIdx;
            r_frameValid   <= w_nextFrameValid;
            r_writeReady   <= (w_nextState != ST_STROBE);
            r_rowSelect    <= w_nextRowSelect;
            r_frameData    <= w_nextFrameData;
            r_dataStrobe   <= w_nextDataStrobe;
            r_frameSelect  <= w_nextFrameSelect;
            r_frameIndex   <= w_nextFrameIndex;
            r_frameStrobe  <= w_nextFrameStrobe;
            r_configActive <= w_nextConfigActive;
            r_configError  <= w_nextConfigError;
        end
    end

    assign WriteReady      = r_writeReady;
    assign RowSelect       = r_rowSelect;
    assign FrameData       = r_frameData;
    assign FrameDataStrobe = r_dataStrobe;
    assign FrameSelect     = r_frameSelect;
    assign FrameIndex      = r_frameIndex;
    assign FrameStrobe     = r_frameStrobe;
    assign ConfigActive    = r_configActive;
    assign ConfigError     = r_configError;

endmodule : config_frame_sequencer
`default_nettype wire

// File: tb/tb_config_frame_sequencer.sv
`default_nettype none
//============================================================================
// Module  : tb_config_frame_sequencer
// Purpose : Directed + randomized bench for config_frame_sequencer.
//           Expected row loads and frame commits are derived from the
//           frames the bench builds and compared against what a monitor
//           collects from the DUT outputs.
// Revision: 1.0 - initial release
//============================================================================
module tb_config_frame_sequencer;

    localparam logic [31:0] c_SYNC = 32'hFAB0_FAB1;
    localparam int          c_ROWS = 16;
    localparam int          c_MAXF = 20;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        WriteReady;
    logic [4:0]  RowSelect;
    logic [31:0] FrameData;
    logic        FrameDataStrobe;
    logic [4:0]  FrameSelect;
    logic [4:0]  FrameIndex;
    logic        FrameStrobe;
    logic        ConfigActive;
    logic        ConfigError;

    config_frame_sequencer u_dut (
        .CLK             (CLK),
        .reset           (reset),
        .WriteData       (WriteData),
        .WriteStrobe     (WriteStrobe),
        .WriteReady      (WriteReady),
        .RowSelect       (RowSelect),
        .FrameData       (FrameData),
        .FrameDataStrobe (FrameDataStrobe),
        .FrameSelect     (FrameSelect),
        .FrameIndex      (FrameIndex),
        .FrameStrobe     (FrameStrobe),
        .ConfigActive    (ConfigActive),
        .ConfigError     (ConfigError)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    logic [36:0] expData[$];
    logic [36:0] obsData[$];
    logic [9:0]  expFrame[$];
    logic [9:0]  obsFrame[$];

    int nCyc          = 0;
    int readyLowCount = 0;
    int lastLowCyc    = -100;
    int lastStrobeCyc = -100;
    int overlapCount  = 0;

    // Monitor: outputs change only on posedge, so sample at negedge.
    always @(negedge CLK) begin
        nCyc <= nCyc + 1;
        if (FrameDataStrobe === 1'b1) obsData.push_back({RowSelect, FrameData});
        if (FrameStrobe === 1'b1) begin
            obsFrame.push_back({FrameSelect, FrameIndex});
            lastStrobeCyc <= nCyc;
        end
        if (WriteReady === 1'b0) begin
            readyLowCount <= readyLowCount + 1;
            lastLowCyc    <= nCyc;
        end
        if (FrameStrobe === 1'b1 && FrameDataStrobe === 1'b1) overlapCount <= overlapCount + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rndData();
        logic [31:0] d;
        d = $urandom;
        while (d == c_SYNC) d = $urandom;
        return d;
    endfunction

    function automatic logic [31:0] mkHeader(input int col, input int idx);
        logic [21:0] junk;
        junk = 22'($urandom);
        return {5'(col), junk, 5'(idx)};
    endfunction

    task automatic idle(input int n);
        WriteStrobe = 1'b0;
        WriteData   = $urandom;
        repeat (n) @(negedge CLK);
    endtask

    // Holds the word until the DUT is ready, then lets one edge accept it.
    task automatic sendWord(input logic [31:0] w);
        int n;
        n = 0;
        WriteData   = w;
        WriteStrobe = 1'b1;
        while (WriteReady !== 1'b1 && n < 8) begin
            @(negedge CLK);
            n++;
        end
        check("ready_wait", WriteReady, 1);
        @(negedge CLK);
    endtask

    // Header plus one word per row. useBase: data = base+row, else random.
    // expect: the sequencer is configuring, so loads/commit are expected.
    task automatic sendFrame(input int col, input int idx, input bit useBase,
                             input logic [31:0] base, input bit expect_);
        logic [31:0] d;
        sendWord(mkHeader(col, idx));
        for (int i = 0; i < c_ROWS; i++) begin
            d = useBase ? base + 32'(i) : rndData();
            if (expect_) expData.push_back({5'(i), d});
            sendWord(d);
        end
        if (expect_ && idx >= 1 && idx <= c_MAXF) expFrame.push_back({5'(col), 5'(idx)});
    endtask

    task automatic checkEvents(input string tag);
        int n;
        check($sformatf("%s_data_count", tag), 64'(obsData.size()), 64'(expData.size()));
        n = (obsData.size() < expData.size()) ? obsData.size() : expData.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_data%0d", tag, i), 64'(obsData[i]), 64'(expData[i]));
        check($sformatf("%s_frame_count", tag), 64'(obsFrame.size()), 64'(expFrame.size()));
        n = (obsFrame.size() < expFrame.size()) ? obsFrame.size() : expFrame.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_frame%0d", tag, i), 64'(obsFrame[i]), 64'(expFrame[i]));
        obsData.delete();  expData.delete();
        obsFrame.delete(); expFrame.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        check($sformatf("%s_ready", tag), WriteReady, 1);
        check($sformatf("%s_outputs", tag),
              {RowSelect, FrameData, FrameDataStrobe, FrameSelect, FrameIndex,
               FrameStrobe, ConfigActive, ConfigError}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowBefore;
        int strobeBefore;
        int col;
        int idx;
        int lastCol;
        int lastIdx;

        WriteStrobe = 1'b0;
        WriteData   = '0;
        reset       = 1'b1;
        repeat (3) @(negedge CLK);
        checkResetOutputs("reset");
        reset = 1'b0;
        @(negedge CLK);

        // Junk before sync is dropped; sync activates.
        sendWord(32'h1234_5678);
        check("junk_active", ConfigActive, 0);
        sendWord(c_SYNC);
        check("sync_active", ConfigActive, 1);
        check("sync_error", ConfigError, 0);

        // Directed frame col 3 / idx 5.
        lowBefore = readyLowCount;
        sendFrame(3, 5, 1'b1, 32'h1000, 1'b1);
        idle(4);
        checkEvents("frame1");
        check("frame1_sel", FrameSelect, 3);
        check("frame1_idx", FrameIndex, 5);
        check("frame1_stall_cycles", readyLowCount - lowBefore, 1);
        check("frame1_strobe_after_stall", lastStrobeCyc - lastLowCyc, 1);

        // Back-to-back random frames with strobe held through the stalls;
        // covers the index boundaries 1 and MaxFramesPerCol.
        lowBefore = readyLowCount;
        lastCol = 0;
        lastIdx = 0;
        for (int k = 0; k < 4; k++) begin
            col = $urandom_range(0, 30);
            idx = (k == 0) ? 1 : (k == 1) ? c_MAXF : $urandom_range(1, c_MAXF);
            sendFrame(col, idx, 1'b0, 32'h0, 1'b1);
            lastCol = col;
            lastIdx = idx;
        end
        idle(4);
        checkEvents("stream");
        check("stream_sel", FrameSelect, lastCol);
        check("stream_idx", FrameIndex, lastIdx);
        check("stream_stall_cycles", readyLowCount - lowBefore, 4);
        check("no_strobe_overlap", overlapCount, 0);

        // Out-of-range indices: data consumed, no commit, sticky error.
        sendFrame(7, 0, 1'b0, 32'h0, 1'b1);
        check("idx0_error", ConfigError, 1);
        sendFrame(9, c_MAXF + 1, 1'b0, 32'h0, 1'b1);
        sendFrame(11, 3, 1'b0, 32'h0, 1'b1);
        idle(4);
        checkEvents("bad_index");
        check("error_sticky", ConfigError, 1);
        check("bad_sel", FrameSelect, 11);
        check("bad_idx", FrameIndex, 3);
        sendWord(c_SYNC);
        check("resync_error", ConfigError, 0);
        check("resync_active", ConfigActive, 1);

        // END then a frame that must be ignored while idle.
        sendWord({5'h1F, 27'h0});
        check("end_active", ConfigActive, 0);
        check("end_sel", FrameSelect, 0);
        check("end_idx", FrameIndex, 0);
        sendFrame(4, 6, 1'b0, 32'h0, 1'b0);
        idle(4);
        checkEvents("after_end");
        check("after_end_active", ConfigActive, 0);

        // Reset in the middle of a frame: loaded rows appear, no commit.
        sendWord(c_SYNC);
        sendWord(mkHeader(2, 8));
        for (int i = 0; i < 7; i++) begin
            logic [31:0] d;
            d = rndData();
            expData.push_back({5'(i), d});
            sendWord(d);
        end
        idle(1);
        strobeBefore = lastStrobeCyc;
        reset = 1'b1;
        @(negedge CLK);
        checkResetOutputs("midreset");
        reset = 1'b0;
        idle(3);
        checkEvents("midreset");
        check("midreset_no_strobe", lastStrobeCyc, strobeBefore);

        // Recovery: sync plus a full frame commits normally.
        sendWord(c_SYNC);
        col = $urandom_range(0, 30);
        idx = $urandom_range(1, c_MAXF);
        sendFrame(col, idx, 1'b0, 32'h0, 1'b1);
        idle(4);
        checkEvents("recover");
        check("recover_sel", FrameSelect, col);
        check("recover_idx", FrameIndex, idx);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_config_frame_sequencer
`default_nettype wire
